// File: rtl/move_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// move_sched_pkg
// Shared definitions for the move scheduler:
//   - game_state encodings (IDLE / PLAY / OVER)
//   - direction bit indices inside btn_dir / movement
//   - tilt sample width
//   - helpers: opposite-pair cancellation and overflow-free tilt magnitude
// -----------------------------------------------------------------------------
package move_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam int TILT_W = 9;

    // Opposite requests on the same axis cancel each other out.
    function automatic logic [3:0] cancel_pairs(input logic [3:0] req);
        logic [3:0] res;
        res = req;
        if (req[DIR_UP] && req[DIR_DOWN]) begin
            res[DIR_UP]   = 1'b0;
            res[DIR_DOWN] = 1'b0;
        end
        if (req[DIR_LEFT] && req[DIR_RIGHT]) begin
            res[DIR_LEFT]  = 1'b0;
            res[DIR_RIGHT] = 1'b0;
        end
        return res;
    endfunction

    // One extra bit so that -256 yields +256 instead of wrapping.
    function automatic logic [TILT_W:0] tilt_mag(input logic signed [TILT_W-1:0] v);
        logic signed [TILT_W:0] ext;
        ext = {v[TILT_W-1], v};
        return ext[TILT_W] ? $unsigned(-ext) : $unsigned(ext);
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// -----------------------------------------------------------------------------
// move_scheduler_if
// Groups the scheduler's request inputs and ball-control outputs.
//   slave  : scheduler side (consumes requests, drives movement/state)
//   master : environment side (drives requests, observes movement/state)
// Signals:
//   btn_dir[3:0]   debounced button levels {right,left,down,up}
//   accel_x/y      signed tilt samples (+x right, +y down)
//   start          debounced start/restart level
//   gameover       level from the ball datapath
//   movement[3:0]  one-cycle move pulses, same bit order as btn_dir
//   mv_src         source of last nonzero move (0 buttons, 1 tilt)
//   game_state     00 IDLE, 01 PLAY, 10 OVER
//   ball_rst       one-cycle ball/score reinitialise pulse
// -----------------------------------------------------------------------------
interface move_scheduler_if;
    import move_sched_pkg::*;

    logic [3:0]               btn_dir;
    logic signed [TILT_W-1:0] accel_x;
    logic signed [TILT_W-1:0] accel_y;
    logic                     start;
    logic                     gameover;
    logic [3:0]               movement;
    logic                     mv_src;
    logic [1:0]               game_state;
    logic                     ball_rst;

    modport slave (
        input  btn_dir, accel_x, accel_y, start, gameover,
        output movement, mv_src, game_state, ball_rst
    );

    modport master (
        output btn_dir, accel_x, accel_y, start, gameover,
        input  movement, mv_src, game_state, ball_rst
    );

endinterface

// File: rtl/move_scheduler_rate_tick.sv
// -----------------------------------------------------------------------------
// rate_tick
// Free-running divider: counts 0..DIV-1 and raises tick while the count sits at
// its terminal value; the count then wraps to 0.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (count -> 0)
//   clr    synchronous clear (count -> 0), used to realign to a new game
//   tick   high for one cycle every DIV cycles
// -----------------------------------------------------------------------------
module rate_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  TERM = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == TERM);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// Game-state FSM plus movement arbiter for the maze ball. Button and tilt
// requests are sampled at their own pulse rates and turned into one-cycle
// registered move pulses while the game is in PLAY.
// Parameters:
//   CLK_HZ, BTN_RATE_HZ, ACC_RATE_HZ  clock and pulse rates in Hz
//   ACC_THRESH                        tilt magnitude that must be exceeded
// Ports:
//   clk    system clock (single clock domain)
//   reset  synchronous active-high reset
//   bus    move_scheduler_if.slave (requests in, movement/state out)
// Build option:
//   MOVE_SCHED_ACCEL_EN  compiles in the tilt divider and tilt arbitration;
//   without it accel_x/accel_y are ignored and mv_src is tied to 0.
// -----------------------------------------------------------------------------
module move_scheduler
    import move_sched_pkg::*;
#(
    parameter int         CLK_HZ      = 100000000,
    parameter int         BTN_RATE_HZ = 90,
    parameter int         ACC_RATE_HZ = 60,
    parameter logic [7:0] ACC_THRESH  = 8'd40
) (
    input  logic               clk,
    input  logic               reset,
    move_scheduler_if.slave    bus
);

    localparam int BTN_DIV = CLK_HZ / BTN_RATE_HZ;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       start_q;
    logic       start_evt;
    logic       play_entry;
    logic       ball_rst_q;
    logic [3:0] movement_q;
    logic [3:0] mv_next;
    logic       btn_tick;

    assign start_evt  = bus.start & ~start_q;
    assign play_entry = (state == ST_IDLE) && start_evt;

    // Dividers clear on the same edge that launches ball_rst, so both counts
    // read 0 throughout the ball_rst cycle and pulses align to the new game.
    rate_tick #(.DIV(BTN_DIV)) u_btn_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (play_entry),
        .tick  (btn_tick)
    );

`ifdef MOVE_SCHED_ACCEL_EN
    localparam int ACC_DIV = CLK_HZ / ACC_RATE_HZ;

    logic              acc_tick;
    logic [TILT_W:0]   mag_x;
    logic [TILT_W:0]   mag_y;
    logic [TILT_W:0]   thresh_ext;
    logic [3:0]        tilt_req;
    logic              mv_src_q;

    rate_tick #(.DIV(ACC_DIV)) u_acc_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (play_entry),
        .tick  (acc_tick)
    );

    assign thresh_ext = {{(TILT_W + 1 - 8){1'b0}}, ACC_THRESH};
    assign mag_x      = tilt_mag(bus.accel_x);
    assign mag_y      = tilt_mag(bus.accel_y);

    // Each axis is judged on its own; equality with the threshold is no move.
    always_comb begin
        tilt_req            = '0;
        tilt_req[DIR_RIGHT] = (mag_x > thresh_ext) && !bus.accel_x[TILT_W-1];
        tilt_req[DIR_LEFT]  = (mag_x > thresh_ext) &&  bus.accel_x[TILT_W-1];
        tilt_req[DIR_DOWN]  = (mag_y > thresh_ext) && !bus.accel_y[TILT_W-1];
        tilt_req[DIR_UP]    = (mag_y > thresh_ext) &&  bus.accel_y[TILT_W-1];
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_evt)    state_next = ST_PLAY;
            ST_PLAY: if (bus.gameover) state_next = ST_OVER;
            ST_OVER: if (start_evt)    state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Any pressed button claims the ball, so tilt ticks are dropped even when
    // the button tick is not due. gameover suppresses the pulse entirely.
    // NOTE: mv_next gets a default before any branch; a path that skipped the
    // assignment would otherwise infer a latch.
    always_comb begin
        mv_next = '0;
        if ((state == ST_PLAY) && !bus.gameover) begin
            if (|bus.btn_dir) begin
                if (btn_tick) begin
                    mv_next = cancel_pairs(bus.btn_dir);
                end
            end
`ifdef MOVE_SCHED_ACCEL_EN
            else if (acc_tick) begin
                mv_next = tilt_req;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            start_q    <= 1'b1;     // start held through reset is not an event
            ball_rst_q <= 1'b0;
            movement_q <= '0;
        end else begin
            state      <= state_next;
            start_q    <= bus.start;
            ball_rst_q <= play_entry;
            movement_q <= mv_next;
        end
    end

`ifdef MOVE_SCHED_ACCEL_EN
    // A nonzero move came from buttons exactly when a button was pressed;
    // empty or cancelled requests keep the previous source.
    always_ff @(posedge clk) begin
        if (reset) begin
            mv_src_q <= 1'b0;
        end else if (|mv_next) begin
            mv_src_q <= ~(|bus.btn_dir);
        end
    end

    assign bus.mv_src = mv_src_q;
`else
    assign bus.mv_src = 1'b0;
`endif

    assign bus.movement   = movement_q;
    assign bus.game_state = state;
    assign bus.ball_rst   = ball_rst_q;

endmodule
